// File: rtl/ctrl_pkg.sv
// Shared types and constants for the exposure/readout controller.
// Holds the FSM state enum, exposure limits, readout length and clamp helper.
package ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXPOSURE,
    S_READOUT
  } state_t;

  localparam int EXP_MIN     = 2;
  localparam int EXP_MAX     = 30;
  localparam int READOUT_LEN = 8;

  function automatic logic [4:0] clamp_exp(input logic [4:0] v);
    if (v < 5'(EXP_MIN)) return 5'(EXP_MIN);
    if (v > 5'(EXP_MAX)) return 5'(EXP_MAX);
    return v;
  endfunction

endpackage

// File: rtl/ctrl_down_counter.sv
// 5-bit loadable down counter with zero flag; times the exposure phase.
// Ports: clk, reset (sync, high), load, dec, value[4:0] -> count[4:0], zero.
module ctrl_down_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       dec,
  input  logic [4:0] value,
  output logic [4:0] count,
  output logic       zero
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (dec && count != '0) begin
      count <= count - 5'd1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/ctrl_exposure_fsm.sv
// Pixel exposure + two-row readout sequencer (IDLE/EXPOSURE/READOUT).
// Ports: clk, reset, exp_start, init[4:0] -> erase, expose, nre_1, nre_2, adc, busy.
module ctrl_exposure_fsm
  import ctrl_pkg::*;
#(
  parameter int READOUT_LEN = ctrl_pkg::READOUT_LEN
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       exp_start,
  input  logic [4:0] init,
  output logic       erase,
  output logic       expose,
  output logic       nre_1,
  output logic       nre_2,
  output logic       adc,
  output logic       busy
);

  localparam logic [2:0] LAST_STEP = 3'(READOUT_LEN - 1);

  state_t     state;
  state_t     next;
  logic [2:0] step;
  logic [4:0] exp_cnt;
  logic       exp_zero;
  logic       load;
  logic       dec;
  logic [4:0] load_val;

  // Counter holds remaining cycles after the current one, so N-1 is loaded
  // and the last exposure cycle is the one that sees zero.
  assign load     = (state == S_IDLE) && exp_start;
  assign dec      = (state == S_EXPOSURE);
  assign load_val = clamp_exp(init) - 5'd1;

  ctrl_down_counter u_exp_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .dec   (dec),
    .value (load_val),
    .count (exp_cnt),
    .zero  (exp_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      step <= '0;
    end else if (state == S_READOUT && step != LAST_STEP) begin
      step <= step + 3'd1;
    end else begin
      step <= '0;
    end
  end

  always_comb begin
    next = state;
    unique case (state)
      S_IDLE:     if (exp_start) next = S_EXPOSURE;
      S_EXPOSURE: if (exp_zero) next = S_READOUT;
      S_READOUT:  if (step == LAST_STEP) next = S_IDLE;
      default:    next = S_IDLE;
    endcase
  end

  // Outputs depend only on registered state and step.
  always_comb begin
    erase  = 1'b0;
    expose = 1'b0;
    nre_1  = 1'b1;
    nre_2  = 1'b1;
    adc    = 1'b0;
    busy   = 1'b1;
    unique case (state)
      S_IDLE: begin
        erase = 1'b1;
        busy  = 1'b0;
      end
      S_EXPOSURE: begin
        expose = 1'b1;
      end
      S_READOUT: begin
        // Row 1 on steps 0-2, gap 3, row 2 on 4-6, gap 7.
        nre_1 = !(step <= 3'd2);
        nre_2 = !(step >= 3'd4 && step <= 3'd6);
        adc   = (step == 3'd1) || (step == 3'd5);
      end
      default: begin
        erase = 1'b1;
        busy  = 1'b0;
      end
    endcase
  end

  logic unused_ok;
  assign unused_ok = ^exp_cnt;

endmodule

// File: tb/tb_ctrl_exposure_fsm.sv
// Scoreboard bench for ctrl_exposure_fsm: expected per-cycle output vectors
// are queued as stimulus is applied and compared on the falling edge.
module tb_ctrl_exposure_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic       exp_start;
  logic [4:0] init;
  logic       erase, expose, nre_1, nre_2, adc, busy;

  always #5 clk = ~clk;

  ctrl_exposure_fsm dut (
    .clk       (clk),
    .reset     (reset),
    .exp_start (exp_start),
    .init      (init),
    .erase     (erase),
    .expose    (expose),
    .nre_1     (nre_1),
    .nre_2     (nre_2),
    .adc       (adc),
    .busy      (busy)
  );

  // {erase, expose, nre_1, nre_2, adc, busy}
  localparam logic [5:0] V_IDLE = 6'b101100;
  localparam logic [5:0] V_EXP  = 6'b011101;

  logic [5:0] ro [8];

  typedef struct {
    string      tag;
    logic [5:0] v;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [5:0] got,
                       input logic [5:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check(e.tag, {erase, expose, nre_1, nre_2, adc, busy}, e.v);
      check({e.tag, "_excl"}, {5'd0, nre_1 | nre_2}, 6'd1);
    end
  end

  task automatic tick(input string tag, input logic [5:0] v);
    exp_t e;
    @(posedge clk);
    #1;
    e.tag = tag;
    e.v   = v;
    q.push_back(e);
  endtask

  // One full sequence; init may be changed at exposure cycle chg_at.
  task automatic run_seq(input string tag, input logic [4:0] iv,
                         input int n, input int chg_at,
                         input logic [4:0] newv);
    exp_start = 1'b1;
    init      = iv;
    for (int i = 0; i < n; i++) begin
      tick($sformatf("%s_exp%0d", tag, i), V_EXP);
      exp_start = 1'b0;
      if (i == chg_at) init = newv;
      if (i == 1) exp_start = 1'b1;
      if (i == 2) exp_start = 1'b0;
    end
    for (int s = 0; s < 8; s++) begin
      tick($sformatf("%s_ro%0d", tag, s), ro[s]);
      exp_start = (s == 2);
    end
    exp_start = 1'b0;
    tick({tag, "_idle"}, V_IDLE);
  endtask

  initial begin
    ro[0] = 6'b000101;
    ro[1] = 6'b000111;
    ro[2] = 6'b000101;
    ro[3] = 6'b001101;
    ro[4] = 6'b001001;
    ro[5] = 6'b001011;
    ro[6] = 6'b001001;
    ro[7] = 6'b001101;

    reset     = 1'b1;
    exp_start = 1'b0;
    init      = 5'd0;
    #1;
    tick("rst0", V_IDLE);
    tick("rst1", V_IDLE);
    reset = 1'b0;
    tick("idle", V_IDLE);

    run_seq("n5", 5'd5, 5, -1, 5'd0);
    run_seq("clamp0", 5'd0, 2, -1, 5'd0);
    run_seq("clamp1", 5'd1, 2, -1, 5'd0);
    run_seq("clamp31", 5'd31, 30, -1, 5'd0);
    run_seq("latch", 5'd10, 10, 4, 5'd3);

    // Reset during exposure cycle 3.
    exp_start = 1'b1;
    init      = 5'd10;
    for (int i = 0; i < 3; i++) begin
      tick("mrst_exp", V_EXP);
      exp_start = 1'b0;
    end
    reset = 1'b1;
    tick("mrst_exp_r", V_IDLE);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) tick("mrst_exp_after", V_IDLE);

    // Reset during readout step 5.
    exp_start = 1'b1;
    init      = 5'd2;
    for (int i = 0; i < 2; i++) begin
      tick("mrst_ro_exp", V_EXP);
      exp_start = 1'b0;
    end
    for (int s = 0; s < 6; s++) tick($sformatf("mrst_ro%0d", s), ro[s]);
    reset = 1'b1;
    tick("mrst_ro_r", V_IDLE);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) tick("mrst_ro_after", V_IDLE);

    // Back-to-back with exp_start held high.
    exp_start = 1'b1;
    init      = 5'd2;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 2; i++) tick($sformatf("b2b%0d_exp", k), V_EXP);
      for (int s = 0; s < 8; s++)
        tick($sformatf("b2b%0d_ro%0d", k, s), ro[s]);
      if (k == 1) exp_start = 1'b0;
      tick($sformatf("b2b%0d_idle", k), V_IDLE);
    end
    tick("b2b_end", V_IDLE);

    // Reset wins over exp_start.
    reset     = 1'b1;
    exp_start = 1'b1;
    init      = 5'd5;
    tick("prio", V_IDLE);
    reset     = 1'b0;
    exp_start = 1'b0;
    tick("prio_after", V_IDLE);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d left want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
